// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory access per load/store, stalls upstream until
// dm_ack or timeout, and registers the MEM/WB fields, including extended load data.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_in,
    input  logic [31:0] alu_res,
    input  logic [31:0] rs2_data,
    input  logic [31:0] pc_add4,
    input  logic [31:0] imm,
    input  logic [1:0]  wb_sel_in,
    input  logic [4:0]  rd_in,
    input  logic        rf_we_in,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_wstrb,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall_mem,
    output logic        wb_valid,
    output logic        wb_rf_we,
    output logic [4:0]  wb_rd,
    output logic [1:0]  wb_sel,
    output logic [31:0] wb_alu_res,
    output logic [31:0] wb_pc_add4,
    output logic [31:0] wb_mem_rd,
    output logic [31:0] wb_imm,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        rf_we_lat_q, rf_we_lat_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_rf_we_q, wb_rf_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic [31:0] wb_alu_res_q, wb_alu_res_d;
    logic [31:0] wb_pc_add4_q, wb_pc_add4_d;
    logic [31:0] wb_mem_rd_q, wb_mem_rd_d;
    logic [31:0] wb_imm_q, wb_imm_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        mem_op, bad_f3, misaligned, illegal, legal_mem;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign mem_op     = valid_in & (mem_re | mem_we);
    assign bad_f3     = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    assign misaligned = ((funct3[1:0] == 2'b01) && alu_res[0]) ||
                        ((funct3[1:0] == 2'b10) && (alu_res[1:0] != 2'b00));
    assign illegal    = mem_op & (bad_f3 | misaligned);
    assign legal_mem  = mem_op & ~illegal;

    always_comb begin
        st_strb = 4'b1111;
        st_data = rs2_data;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << alu_res[1:0];
                st_data = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << alu_res[1:0];
                st_data = {2{rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = dm_rdata[7:0];
            2'b01:   ld_byte = dm_rdata[15:8];
            2'b10:   ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        rf_we_lat_d  = rf_we_lat_q;
        wb_valid_d   = wb_valid_q;
        wb_rf_we_d   = wb_rf_we_q;
        wb_rd_d      = wb_rd_q;
        wb_sel_d     = wb_sel_q;
        wb_alu_res_d = wb_alu_res_q;
        wb_pc_add4_d = wb_pc_add4_q;
        wb_mem_rd_d  = wb_mem_rd_q;
        wb_imm_d     = wb_imm_q;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;
        stall_mem    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!valid_in) begin
                    wb_valid_d = 1'b0;
                    wb_rf_we_d = 1'b0;
                end else begin
                    wb_rd_d      = rd_in;
                    wb_sel_d     = wb_sel_in;
                    wb_alu_res_d = alu_res;
                    wb_pc_add4_d = pc_add4;
                    wb_imm_d     = imm;
                    if (legal_mem) begin
                        stall_mem   = 1'b1;
                        state_d     = BUSY;
                        cnt_d       = '0;
                        addr_d      = alu_res;
                        wdata_d     = st_data;
                        wstrb_d     = mem_we ? st_strb : 4'b0000;
                        we_d        = mem_we;
                        funct3_d    = funct3;
                        rf_we_lat_d = rf_we_in & ~mem_we;
                        wb_valid_d  = 1'b0;
                        wb_rf_we_d  = 1'b0;
                    end else if (illegal) begin
                        misalign_d = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_rf_we_d = 1'b0;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rf_we_d = rf_we_in;
                    end
                end
            end
            BUSY: begin
                // ack wins over timeout when both land on the last wait cycle
                if (dm_ack) begin
                    state_d     = IDLE;
                    wb_valid_d  = 1'b1;
                    wb_rf_we_d  = rf_we_lat_q;
                    wb_mem_rd_d = ld_ext;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d    = IDLE;
                    bus_err_d  = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_rf_we_d = 1'b0;
                end else begin
                    stall_mem = 1'b1;
                    cnt_d     = 8'(cnt_q + 8'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            rf_we_lat_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rf_we_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_sel_q     <= '0;
            wb_alu_res_q <= '0;
            wb_pc_add4_q <= '0;
            wb_mem_rd_q  <= '0;
            wb_imm_q     <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            rf_we_lat_q  <= rf_we_lat_d;
            wb_valid_q   <= wb_valid_d;
            wb_rf_we_q   <= wb_rf_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_sel_q     <= wb_sel_d;
            wb_alu_res_q <= wb_alu_res_d;
            wb_pc_add4_q <= wb_pc_add4_d;
            wb_mem_rd_q  <= wb_mem_rd_d;
            wb_imm_q     <= wb_imm_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign dm_req       = (state_q == BUSY);
    assign dm_we        = we_q;
    assign dm_addr      = {addr_q[31:2], 2'b00};
    assign dm_wdata     = wdata_q;
    assign dm_wstrb     = wstrb_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rf_we     = wb_rf_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_sel       = wb_sel_q;
    assign wb_alu_res   = wb_alu_res_q;
    assign wb_pc_add4   = wb_pc_add4_q;
    assign wb_mem_rd    = wb_mem_rd_q;
    assign wb_imm       = wb_imm_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single-cycle ops plus hand sequences
// for load/store handshakes, timeout, ack-in-idle and reset during an access.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_in;
    logic [31:0] alu_res, rs2_data, pc_add4, imm;
    logic [1:0]  wb_sel_in;
    logic [4:0]  rd_in;
    logic        rf_we_in, mem_re, mem_we;
    logic [2:0]  funct3;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall_mem, wb_valid, wb_rf_we;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_sel;
    logic [31:0] wb_alu_res, wb_pc_add4, wb_mem_rd, wb_imm;
    logic        misalign_err, bus_err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .alu_res(alu_res),
        .rs2_data(rs2_data), .pc_add4(pc_add4), .imm(imm), .wb_sel_in(wb_sel_in),
        .rd_in(rd_in), .rf_we_in(rf_we_in), .mem_re(mem_re), .mem_we(mem_we),
        .funct3(funct3), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall_mem(stall_mem), .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_rd(wb_rd),
        .wb_sel(wb_sel), .wb_alu_res(wb_alu_res), .wb_pc_add4(wb_pc_add4),
        .wb_mem_rd(wb_mem_rd), .wb_imm(wb_imm), .misalign_err(misalign_err),
        .bus_err(bus_err)
    );

    typedef struct {
        logic        valid, re, we;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic        rf_we;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] pc, immv;
        logic        e_valid, e_rf_we, e_mis;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; mem_re = 1'b0; mem_we = 1'b0; funct3 = '0;
        alu_res = '0; rs2_data = '0; pc_add4 = '0; imm = '0;
        wb_sel_in = '0; rd_in = '0; rf_we_in = 1'b0;
    endtask

    // Present one memory op, ack it in BUSY cycle ack_at, check bus side and writeback.
    task automatic mem_op(input string nm, input logic re, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic rfwe,
                          input int unsigned ack_at, input logic [31:0] rdata,
                          input logic [31:0] exp_rd, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
        valid_in = 1'b1; mem_re = re; mem_we = we; funct3 = f3; alu_res = addr;
        rs2_data = wd; rf_we_in = rfwe; rd_in = 5'd7; wb_sel_in = 2'b10;
        @(negedge clk);
        chk({nm, "_stall_idle"}, 32'(stall_mem), 32'd1);
        chk({nm, "_req_idle"}, 32'(dm_req), 32'd0);
        @(posedge clk); #1;
        for (int unsigned i = 0; i <= ack_at; i++) begin
            if (i == ack_at) begin
                dm_ack = 1'b1; dm_rdata = rdata;
            end
            @(negedge clk);
            chk($sformatf("%s_req_b%0d", nm, i), 32'(dm_req), 32'd1);
            chk($sformatf("%s_addr_b%0d", nm, i), dm_addr, {addr[31:2], 2'b00});
            chk($sformatf("%s_we_b%0d", nm, i), 32'(dm_we), 32'(we));
            chk($sformatf("%s_stall_b%0d", nm, i), 32'(stall_mem), 32'(i != ack_at));
            if (we) begin
                chk($sformatf("%s_strb_b%0d", nm, i), 32'(dm_wstrb), 32'(exp_strb));
                chk($sformatf("%s_wdata_b%0d", nm, i), dm_wdata, exp_wdata);
            end
            @(posedge clk); #1;
        end
        dm_ack = 1'b0; dm_rdata = '0;
        idle_inputs();
        chk({nm, "_wb_valid"}, 32'(wb_valid), 32'd1);
        chk({nm, "_wb_rf_we"}, 32'(wb_rf_we), 32'(rfwe & ~we));
        chk({nm, "_wb_rd"}, 32'(wb_rd), 32'd7);
        chk({nm, "_req_done"}, 32'(dm_req), 32'd0);
        if (!we) chk({nm, "_mem_rd"}, wb_mem_rd, exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              v  re we f3      alu           rfwe rd     sel    pc        imm            ev ew em
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 1'b1, 5'd5,  2'b00, 32'h4,  32'h0,         1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0,         1'b1, 5'd1,  2'b01, 32'h44, 32'h0,         1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0,         1'b1, 5'd31, 2'b11, 32'h8,  32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'b000, 32'h0,         1'b1, 5'd9,  2'b00, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0101, 1'b1, 5'd3,  2'b10, 32'hC,  32'h0,         1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'b000, 32'h0,         1'b0, 5'd0,  2'b00, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0201, 1'b1, 5'd4,  2'b10, 32'h10, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0202, 1'b1, 5'd6,  2'b00, 32'h14, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b011, 32'h0,         1'b1, 5'd8,  2'b10, 32'h18, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'b110, 32'h0,         1'b0, 5'd10, 2'b00, 32'h1C, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0003, 1'b1, 5'd11, 2'b10, 32'h20, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 3'b111, 32'hFFFF_FFFF, 1'b0, 5'd2,  2'b00, 32'h24, 32'h5,         1'b1, 1'b0, 1'b0};

        idle_inputs();
        dm_ack = 1'b0; dm_rdata = '0; rstn = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_stall", 32'(stall_mem), 32'd0);
        chk("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
        chk("rst_wb_alu", wb_alu_res, 32'd0);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            valid_in = vecs[i].valid; mem_re = vecs[i].re; mem_we = vecs[i].we;
            funct3 = vecs[i].f3; alu_res = vecs[i].alu; rs2_data = 32'h5A5A_5A5A;
            rf_we_in = vecs[i].rf_we; rd_in = vecs[i].rd; wb_sel_in = vecs[i].sel;
            pc_add4 = vecs[i].pc; imm = vecs[i].immv;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall_mem), 32'd0);
            chk($sformatf("v%0d_req", i), 32'(dm_req), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_wb_rf_we", i), 32'(wb_rf_we), 32'(vecs[i].e_rf_we));
            chk($sformatf("v%0d_misalign", i), 32'(misalign_err), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d_bus_err", i), 32'(bus_err), 32'd0);
            chk($sformatf("v%0d_req_after", i), 32'(dm_req), 32'd0);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
                chk($sformatf("v%0d_wb_sel", i), 32'(wb_sel), 32'(vecs[i].sel));
                chk($sformatf("v%0d_wb_alu", i), wb_alu_res, vecs[i].alu);
                chk($sformatf("v%0d_wb_pc4", i), wb_pc_add4, vecs[i].pc);
                chk($sformatf("v%0d_wb_imm", i), wb_imm, vecs[i].immv);
            end
        end
        idle_inputs();

        // Timeout: lw never acknowledged, TIMEOUT=4 gives four request cycles.
        valid_in = 1'b1; mem_re = 1'b1; funct3 = 3'b010; alu_res = 32'h100; rf_we_in = 1'b1;
        @(negedge clk);
        chk("to_stall_idle", 32'(stall_mem), 32'd1);
        @(posedge clk); #1;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("to_req_b%0d", i), 32'(dm_req), 32'd1);
            chk($sformatf("to_stall_b%0d", i), 32'(stall_mem), 32'(i != 3));
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_wb_valid", 32'(wb_valid), 32'd1);
        chk("to_wb_rf_we", 32'(wb_rf_we), 32'd0);
        chk("to_req_off", 32'(dm_req), 32'd0);
        @(posedge clk); #1;
        chk("to_bus_err_clr", 32'(bus_err), 32'd0);
        chk("to_wb_valid_clr", 32'(wb_valid), 32'd0);

        // Ack on the fourth BUSY cycle (counter at TIMEOUT-1) must still complete the load.
        mem_op("lb",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0,         1'b1, 3, 32'h80FF_FF00, 32'hFFFF_FF80, 4'h0,    32'h0);
        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h101, 32'h0,         1'b1, 0, 32'h1234_5678, 32'h0000_0056, 4'h0,    32'h0);
        mem_op("lh",  1'b1, 1'b0, 3'b001, 32'h002, 32'h0,         1'b1, 1, 32'h8001_0000, 32'hFFFF_8001, 4'h0,    32'h0);
        mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h002, 32'h0,         1'b1, 0, 32'h8001_0000, 32'h0000_8001, 4'h0,    32'h0);
        mem_op("lw",  1'b1, 1'b0, 3'b010, 32'h00C, 32'h0,         1'b1, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'h0,    32'h0);
        mem_op("sh",  1'b0, 1'b1, 3'b001, 32'h202, 32'hABCD_1234, 1'b1, 0, 32'h0,         32'h0,         4'b1100, 32'h1234_1234);
        mem_op("sb",  1'b0, 1'b1, 3'b000, 32'h001, 32'h0000_0055, 1'b1, 1, 32'h0,         32'h0,         4'b0010, 32'h5555_5555);
        mem_op("sw",  1'b0, 1'b1, 3'b010, 32'h010, 32'h1122_3344, 1'b0, 0, 32'h0,         32'h0,         4'b1111, 32'h1122_3344);
        mem_op("rw",  1'b1, 1'b1, 3'b000, 32'h003, 32'h0000_00A5, 1'b1, 0, 32'h0,         32'h0,         4'b1000, 32'hA5A5_A5A5);

        // Stray ack while idle.
        dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("ia_stall", 32'(stall_mem), 32'd0);
        chk("ia_req", 32'(dm_req), 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0; dm_rdata = '0;
        chk("ia_wb_valid", 32'(wb_valid), 32'd0);
        chk("ia_req_after", 32'(dm_req), 32'd0);

        // Reset in the second BUSY cycle abandons the access.
        valid_in = 1'b1; mem_re = 1'b1; funct3 = 3'b010; alu_res = 32'h104; rf_we_in = 1'b1; rd_in = 5'd12;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rb_req_busy", 32'(dm_req), 32'd1);
        rstn = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        chk("rb_req", 32'(dm_req), 32'd0);
        chk("rb_stall", 32'(stall_mem), 32'd0);
        chk("rb_wb_valid", 32'(wb_valid), 32'd0);
        chk("rb_wb_rf_we", 32'(wb_rf_we), 32'd0);
        chk("rb_wb_rd", 32'(wb_rd), 32'd0);
        chk("rb_dm_addr", dm_addr, 32'd0);
        chk("rb_errs", {30'd0, misalign_err, bus_err}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rb_no_wb", 32'(wb_valid), 32'd0);
        valid_in = 1'b1; alu_res = 32'h0000_1234; rd_in = 5'd5; rf_we_in = 1'b1; wb_sel_in = 2'b00;
        @(negedge clk);
        chk("rb_alu_stall", 32'(stall_mem), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        chk("rb_alu_valid", 32'(wb_valid), 32'd1);
        chk("rb_alu_res", wb_alu_res, 32'h0000_1234);
        chk("rb_alu_rd", 32'(wb_rd), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
